cache_port_arbiter: RTL

Round-robin arbiter that shares one cache access port among N requesters: instruction fetch, data load/store, and writeback. It picks the winner by rotating-priority encoding of the request vector and holds the grant until the cache signals transaction completion. A watchdog forces release if a transaction hangs. It sits between the requesters and the cache controller's single request input.

---
 rtl/cache_port_arbiter_if.sv | 30 +++
 rtl/cache_port_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cache_port_arbiter_if.sv
// Purpose: request/grant bundle between the requesters and the cache port arbiter.
// Signals:
//   req         N      per-requester request level
//   done        1      cache completion pulse for the granted transaction
//   grant       N      one-hot grant, or zero
//   grant_idx   IDX_W  binary index of the granted requester (0 when idle)
//   grant_valid 1      a grant is held
//   timeout     1      one-cycle pulse when the watchdog forced a release
// Modports: master = requester/cache side, slave = arbiter side.
interface cache_port_arbiter_if #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) ();
   logic [N-1:0]     req;
   logic             done;
   logic [N-1:0]     grant;
   logic [IDX_W-1:0] grant_idx;
   logic             grant_valid;
   logic             timeout;

   modport master (
      output req, done,
      input  grant, grant_idx, grant_valid, timeout
   );

   modport slave (
      input  req, done,
      output grant, grant_idx, grant_valid, timeout
   );
endinterface

// File: rtl/cache_port_arbiter.sv
// Purpose: round-robin arbiter sharing one cache access port among N requesters.
//          A grant is held until the cache pulses done or the watchdog expires;
//          release re-arbitrates in the same cycle with rotated priority.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  cache_port_arbiter_if.slave (req/done in, grant/grant_idx/grant_valid/timeout out)
// All outputs are registered.
module cache_port_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned IDX_W   = 2,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   cache_port_arbiter_if.slave  bus
);

   localparam bit               WD_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
   localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     grant_q, grant_d;
   logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
   logic             grant_valid_q, grant_valid_d;
   logic             timeout_q, timeout_d;

   logic [IDX_W-1:0] ptr_inc_c;
   logic [IDX_W-1:0] base_c;
   logic [2*N-1:0]   req2_c;
   logic [N-1:0]     rot_c;
   logic [IDX_W-1:0] off_c;
   logic [IDX_W:0]   sum_c;
   logic             win_found_c;
   logic [IDX_W-1:0] win_idx_c;
   logic             wd_expire_c;
   logic             release_c;

   // Pointer after the current holder, wrapping N-1 -> 0 for any N.
   assign ptr_inc_c = (grant_idx_q == IDX_LAST) ? '0 : grant_idx_q + IDX_W'(1);

   // On release the scan already starts from the updated pointer.
   assign base_c = (state_q == ST_BUSY) ? ptr_inc_c : ptr_q;

   // Rotate req so bit 0 corresponds to the highest-priority requester.
   assign req2_c = {bus.req, bus.req} >> base_c;
   assign rot_c  = req2_c[N-1:0];

   // Lowest set bit of the rotated vector; descending scan leaves the smallest offset.
   always_comb begin
      win_found_c = 1'b0;
      off_c       = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot_c[k]) begin
            win_found_c = 1'b1;
            off_c       = IDX_W'(k);
         end
      end
   end

   // Undo the rotation modulo N.
   always_comb begin
      sum_c = {1'b0, base_c} + {1'b0, off_c};
      if (sum_c >= N_EXT) begin
         sum_c = sum_c - N_EXT;
      end
      win_idx_c = sum_c[IDX_W-1:0];
   end

   assign wd_expire_c = WD_EN && (cnt_q == CNT_LAST);
   assign release_c   = (state_q == ST_BUSY) && (bus.done || wd_expire_c);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         cnt_q         <= '0;
         grant_q       <= '0;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         grant_q       <= grant_d;
         grant_idx_q   <= grant_idx_d;
         grant_valid_q <= grant_valid_d;
         timeout_q     <= timeout_d;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      grant_d       = grant_q;
      grant_idx_d   = grant_idx_q;
      grant_valid_d = grant_valid_q;
      timeout_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (win_found_c) begin
               state_d       = ST_BUSY;
               grant_d       = N'(1) << win_idx_c;
               grant_idx_d   = win_idx_c;
               grant_valid_d = 1'b1;
               cnt_d         = '0;
            end else begin
               grant_d       = '0;
               grant_idx_d   = '0;
               grant_valid_d = 1'b0;
            end
         end

         ST_BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (release_c) begin
               ptr_d     = ptr_inc_c;
               // done takes precedence: a coinciding completion is not a timeout.
               timeout_d = wd_expire_c && !bus.done;
               cnt_d     = '0;
               if (win_found_c) begin
                  grant_d       = N'(1) << win_idx_c;
                  grant_idx_d   = win_idx_c;
                  grant_valid_d = 1'b1;
               end else begin
                  state_d       = ST_IDLE;
                  grant_d       = '0;
                  grant_idx_d   = '0;
                  grant_valid_d = 1'b0;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.grant       = grant_q;
   assign bus.grant_idx   = grant_idx_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.timeout     = timeout_q;

endmodule
